// File: rtl/adc_pkg.sv
// Shared definitions for the ADC front end and its millivolt/BCD consumer.
package adc_pkg;

    localparam int ADC_W  = 8;
    localparam int DIGITS = 4;
    localparam int MV_W   = 14;
    localparam int BCD_W  = 16;
    localparam int PROD_W = 22;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCALE = 2'd1,
        ST_CONV  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per clock, MV_W iterations per run.
module bin2bcd_seq
    import adc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MV_W-1:0]   bin,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    localparam int SR_W = BCD_W + MV_W;

    logic [SR_W-1:0] sr_q, sr_d;
    logic [3:0]      it_q, it_d;
    logic [SR_W-1:0] adj;

    always_comb begin
        sr_d = sr_q;
        it_d = it_q;
        adj  = sr_q;
        if (start) begin
            sr_d = {{BCD_W{1'b0}}, bin};
            it_d = 4'(MV_W);
        end else if (it_q != 4'd0) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (adj[MV_W + 4*i +: 4] >= 4'd5) begin
                    adj[MV_W + 4*i +: 4] = adj[MV_W + 4*i +: 4] + 4'd3;
                end
            end
            sr_d = adj << 1;
            it_d = it_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
            it_q <= '0;
        end else begin
            sr_q <= sr_d;
            it_q <= it_d;
        end
    end

    // done marks the cycle whose closing edge performs the final iteration,
    // so the caller can be ready to take bcd on the very next edge.
    assign busy = (it_q != 4'd0);
    assign done = (it_q == 4'd1);
    assign bcd  = sr_q[SR_W-1:MV_W];

endmodule

// File: rtl/adc_volt_bcd.sv
// Captures ADC conversions, block-averages them, scales to mV and emits packed BCD.
module adc_volt_bcd
    import adc_pkg::*;
#(
    parameter int AVG_LOG2 = 3,
    parameter int VREF_MV  = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic [ADC_W-1:0]  data,
    output logic [ADC_W-1:0]  avg_data,
    output logic [BCD_W-1:0]  volt_bcd,
    output logic              bcd_valid,
    output logic              overrun
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic              cs_d_q, cs_d_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADC_W-1:0]  avg_r_q, avg_r_d;

    logic              cs_edge;
    logic              block_done;
    logic [ACC_W-1:0]  sum;
    logic [PROD_W-1:0] prod;
    logic [MV_W-1:0]   mv;

    state_e            state_q;
    logic [ADC_W-1:0]  avg_data_q;
    logic [BCD_W-1:0]  volt_bcd_q;
    logic              bcd_valid_q;
    logic              overrun_q;

    logic              conv_start;
    logic              conv_busy;
    logic              conv_done;
    logic [BCD_W-1:0]  conv_bcd;

    always_comb begin
        cs_edge    = cs_n & ~cs_d_q;
        block_done = cs_edge & ((AVG_LOG2 == 0) ? 1'b1 : (&cnt_q));
        sum        = acc_q + ACC_W'(data);
        cs_d_d     = cs_n;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        avg_r_d    = avg_r_q;
        if (cs_edge) begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = block_done ? '0 : sum;
        end
        // A block finishing while a conversion is in flight keeps the old average.
        if (block_done && (state_q == ST_IDLE)) begin
            avg_r_d = sum[ACC_W-1:AVG_LOG2];
        end
        prod = PROD_W'(avg_r_q) * PROD_W'(VREF_MV);
        mv   = MV_W'(prod >> 8);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_d_q  <= 1'b1;
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_r_q <= '0;
        end else begin
            cs_d_q  <= cs_d_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            avg_r_q <= avg_r_d;
        end
    end

    assign conv_start = (state_q == ST_SCALE);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (mv),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            avg_data_q  <= '0;
            volt_bcd_q  <= '0;
            bcd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            bcd_valid_q <= 1'b0;
            if (block_done && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (block_done) state_q <= ST_SCALE;
                end
                ST_SCALE: begin
                    state_q <= ST_CONV;
                end
                ST_CONV: begin
                    if (conv_busy && conv_done) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    volt_bcd_q  <= conv_bcd;
                    avg_data_q  <= avg_r_q;
                    bcd_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign avg_data  = avg_data_q;
    assign volt_bcd  = volt_bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_volt_bcd.sv
// Bench for adc_volt_bcd: one instance without averaging, one averaging eight samples.
module tb_adc_volt_bcd;

    // Handshake: an ADC sample is offered by raising cs_n with data stable on that
    // cycle; a result is valid on the single cycle bcd_valid is high.

    logic        clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst0, cs0, v0, ov0;
    logic [7:0]  data0, avg0;
    logic [15:0] bcd0;
    logic        rst3, cs3, v3, ov3;
    logic [7:0]  data3, avg3;
    logic [15:0] bcd3;

    adc_volt_bcd #(.AVG_LOG2(0), .VREF_MV(5000)) dut0 (
        .clk(clk), .rst(rst0), .cs_n(cs0), .data(data0),
        .avg_data(avg0), .volt_bcd(bcd0), .bcd_valid(v0), .overrun(ov0)
    );

    adc_volt_bcd #(.AVG_LOG2(3), .VREF_MV(5000)) dut3 (
        .clk(clk), .rst(rst3), .cs_n(cs3), .data(data3),
        .avg_data(avg3), .volt_bcd(bcd3), .bcd_valid(v3), .overrun(ov3)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    logic [23:0] exp0_q[$];
    logic [23:0] exp3_q[$];
    int          t0_0_q[$];
    int          t0_3_q[$];

    int m_acc = 0;
    int m_cnt = 0;

    typedef struct {
        logic [7:0]  d;
        logic [15:0] bcd;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_mv(input int a);
        return (a * 5000) / 256;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Scoreboard: every bcd_valid pops one expectation and checks value and latency.
    always @(negedge clk) begin
        logic [23:0] e;
        int          t;
        if (v0) begin
            if (exp0_q.size() == 0) check("dut0_unexpected_valid", 32'(v0), 32'd0);
            else begin
                e = exp0_q.pop_front();
                t = t0_0_q.pop_front();
                check("dut0_volt_bcd", 32'(bcd0), 32'(e[15:0]));
                check("dut0_avg_data", 32'(avg0), 32'(e[23:16]));
                check("dut0_latency", 32'(cyc - t), 32'd16);
            end
        end
        if (v3) begin
            if (exp3_q.size() == 0) check("dut3_unexpected_valid", 32'(v3), 32'd0);
            else begin
                e = exp3_q.pop_front();
                t = t0_3_q.pop_front();
                check("dut3_volt_bcd", 32'(bcd3), 32'(e[15:0]));
                check("dut3_avg_data", 32'(avg3), 32'(e[23:16]));
                check("dut3_latency", 32'(cyc - t), 32'd16);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One sample on dut0; the next sample may start gap cycles after this one.
    task automatic sample0(input logic [7:0] d, input int gap, input bit chk, input logic [15:0] eb);
        @(negedge clk);
        data0 = d;
        cs0   = 1'b1;
        if (chk) begin
            exp0_q.push_back({d, eb});
            t0_0_q.push_back(cyc + 1);
        end
        @(negedge clk);
        cs0   = 1'b0;
        data0 = 8'($urandom_range(0, 255));
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic sample3(input logic [7:0] d, input int gap);
        logic [7:0] a;
        @(negedge clk);
        data3 = d;
        cs3   = 1'b1;
        m_acc += int'(d);
        m_cnt++;
        if (m_cnt == 8) begin
            a = 8'(m_acc / 8);
            exp3_q.push_back({a, to_bcd(exp_mv(int'(a)))});
            t0_3_q.push_back(cyc + 1);
            m_acc = 0;
            m_cnt = 0;
        end
        @(negedge clk);
        cs3   = 1'b0;
        data3 = 8'($urandom_range(0, 255));
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp0_q.size() + exp3_q.size()) != 0; i++) @(negedge clk);
        idle(5);
        check("drain_dut0", 32'(exp0_q.size()), 32'd0);
        check("drain_dut3", 32'(exp3_q.size()), 32'd0);
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: got timeout expected finish");
        fails++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h66, 16'h1992};
        tbl[1] = '{8'h00, 16'h0000};
        tbl[2] = '{8'hFF, 16'h4980};
        tbl[3] = '{8'h01, 16'h0019};
        tbl[4] = '{8'h80, 16'h2500};
        tbl[5] = '{8'h33, 16'h0996};
        tbl[6] = '{8'hAA, 16'h3320};

        rst0 = 1'b1; rst3 = 1'b1;
        cs0 = 1'b1;  cs3 = 1'b1;
        data0 = 8'h00; data3 = 8'h00;
        idle(5);
        rst0 = 1'b0; rst3 = 1'b0;
        idle(100);
        check("rst_dut0_bcd", 32'(bcd0), 32'd0);
        check("rst_dut0_avg", 32'(avg0), 32'd0);
        check("rst_dut0_valid", 32'(v0), 32'd0);
        check("rst_dut0_overrun", 32'(ov0), 32'd0);
        check("rst_dut3_bcd", 32'(bcd3), 32'd0);
        check("rst_dut3_avg", 32'(avg3), 32'd0);
        check("rst_dut3_valid", 32'(v3), 32'd0);
        check("rst_dut3_overrun", 32'(ov3), 32'd0);
        cs0 = 1'b0; cs3 = 1'b0;
        idle(2);

        // Single conversions, widely spaced.
        for (int i = 0; i < 7; i++) sample0(tbl[i].d, 20, 1'b1, tbl[i].bcd);
        drain();
        check("tbl_dut0_overrun", 32'(ov0), 32'd0);

        // 17-cycle spacing is the tightest accepted pair.
        sample0(8'h33, 17, 1'b1, 16'h0996);
        sample0(8'h66, 17, 1'b1, 16'h1992);
        idle(20);
        drain();
        check("gap17_overrun", 32'(ov0), 32'd0);

        // 16-cycle spacing lands on DONE: overrun, second sample discarded.
        sample0(8'hFF, 16, 1'b1, 16'h4980);
        sample0(8'h00, 16, 1'b0, 16'h0000);
        check("gap16_overrun", 32'(ov0), 32'd1);
        drain();
        check("gap16_bcd_kept", 32'(bcd0), 32'h4980);

        @(negedge clk); rst0 = 1'b1;
        @(negedge clk); rst0 = 1'b0;
        check("rst1_overrun", 32'(ov0), 32'd0);
        check("rst1_bcd", 32'(bcd0), 32'd0);

        // cs_n toggling every 2 clocks.
        sample0(8'hFF, 4, 1'b1, 16'h4980);
        check("toggle_first_overrun", 32'(ov0), 32'd0);
        sample0(8'hFF, 4, 1'b0, 16'h0000);
        check("toggle_second_overrun", 32'(ov0), 32'd1);
        sample0(8'hFF, 4, 1'b0, 16'h0000);
        sample0(8'hFF, 4, 1'b0, 16'h0000);
        idle(30);
        drain();
        check("toggle_sticky_overrun", 32'(ov0), 32'd1);
        check("toggle_bcd", 32'(bcd0), 32'h4980);

        // Reset pulsed at T5 of a conversion.
        @(negedge clk);
        data0 = 8'h55;
        cs0   = 1'b1;
        @(negedge clk);
        cs0   = 1'b0;
        repeat (4) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        idle(30);
        check("midrst_bcd", 32'(bcd0), 32'd0);
        check("midrst_avg", 32'(avg0), 32'd0);
        check("midrst_overrun", 32'(ov0), 32'd0);
        sample0(8'h80, 20, 1'b1, 16'h2500);
        drain();

        // Eight-sample averaging.
        for (int i = 0; i < 8; i++) sample3(8'hAA, 4);
        drain();
        check("avg_AA_bcd", 32'(bcd3), 32'h3320);
        for (int i = 0; i < 4; i++) sample3(8'h00, 4);
        for (int i = 0; i < 4; i++) sample3(8'hFF, 4);
        drain();
        check("avg_127_bcd", 32'(bcd3), 32'h2480);
        for (int i = 0; i < 8; i++) sample3(8'hFF, 3);
        drain();
        check("avg_FF_bcd", 32'(bcd3), 32'h4980);
        for (int i = 0; i < 8; i++) sample3(8'h00, 5);
        drain();
        check("avg_00_bcd", 32'(bcd3), 32'h0000);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) sample3(8'($urandom_range(0, 255)), $urandom_range(3, 6));
        end
        drain();
        check("avg_dut3_overrun", 32'(ov3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
